// File: rtl/sac_seq_ctl.sv
// sac_seq_ctl: microcycle divider, halt/step FSM, parity, microtrap and trap service sequencing
module sac_seq_ctl #(
   parameter int DIV   = 3,
   parameter int NTRAP = 6,
   parameter int VEC_W = 4,
   parameter int IRD_W = 3
) (
   input  logic             base_clk_h,
   input  logic             sac_reset_h,
   input  logic [1:0]       clk_ctl_h,
   input  logic             mem_stall_h,
   input  logic             gen_dest_inh_l,
   input  logic             cs_par_err_h,
   input  logic             micro_trap_l,
   input  logic             but_cc_a_h,
   input  logic [2:0]       but_h,
   input  logic [NTRAP-1:0] trap_req_h,
   input  logic [NTRAP-1:0] trap_mask_h,
   output logic             tick_h,
   output logic             mken_h,
   output logic             dken_h,
   output logic             halt_l,
   output logic             do_service_l,
   output logic [VEC_W-1:0] trap_vec_h,
   output logic             uvector_h,
   output logic [IRD_W-1:0] ird_ctr_h
);
   localparam int CW = $clog2(DIV);
   localparam logic [1:0] S_RUN  = 2'd0;
   localparam logic [1:0] S_STEP = 2'd1;
   localparam logic [1:0] S_HALT = 2'd2;
   logic [CW-1:0]    cnt;
   logic [1:0]       state, state_nxt, ctl_prev;
   logic             dblerr, dbl_set, cs_err_ff, utrap_ff, stall_ff, mt_prev;
   logic             halt_ff, fall, utrap_stall, adv, ird1;
   logic [NTRAP-1:0] svc_reg, pend;
   logic [IRD_W-1:0] ird_nxt;
   assign tick_h       = cnt == CW'(DIV - 1);
   assign fall         = mt_prev & ~micro_trap_l;
   assign utrap_stall  = stall_ff | fall;
   assign halt_ff      = state == S_HALT;
   assign adv          = tick_h & ~mem_stall_h & ~halt_ff & ~utrap_stall;
   assign ird1         = but_cc_a_h & (but_h == 3'd4 | but_h == 3'd5);
   assign dbl_set      = tick_h & cs_par_err_h & cs_err_ff;
   assign pend         = trap_req_h & trap_mask_h;
   assign mken_h       = adv;
   assign dken_h       = adv & gen_dest_inh_l;
   assign halt_l       = ~halt_ff;
   assign uvector_h    = utrap_ff & ~utrap_stall;
   // an active microtrap hides any latched service request
   assign do_service_l = ~(|svc_reg & ~cs_par_err_h & ~utrap_ff);
   assign ird_nxt      = ird1 ? '1 :
                         ((but_h == 3'd1 && ird_ctr_h[IRD_W-1:1] == '0) || but_h == 3'd6) ?
                         ird_ctr_h + IRD_W'(1) : ird_ctr_h;
   always_comb begin
      state_nxt = state;
      if (dblerr | dbl_set)
         state_nxt = S_HALT;
      else if (tick_h)
         state_nxt = (state == S_RUN)  ? (clk_ctl_h == 2'd3 ? S_RUN : clk_ctl_h == 2'd2 ? S_STEP : S_HALT) :
                     (state == S_STEP) ? (adv ? S_HALT : S_STEP) :
                     (clk_ctl_h == 2'd3) ? S_RUN :
                     (clk_ctl_h == 2'd2 && ctl_prev != 2'd2) ? S_STEP : S_HALT;
   end
   always_comb begin
      trap_vec_h = '0;
      for (int i = NTRAP - 1; i >= 0; i--)
         if (svc_reg[i]) trap_vec_h = VEC_W'(i);
   end
   always_ff @(posedge base_clk_h) begin
      if (sac_reset_h) begin
         cnt       <= '0;
         state     <= S_HALT;
         ctl_prev  <= 2'd0;
         dblerr    <= 1'b0;
         cs_err_ff <= 1'b0;
         utrap_ff  <= 1'b0;
         stall_ff  <= 1'b0;
         mt_prev   <= micro_trap_l;
         svc_reg   <= '0;
         ird_ctr_h <= '0;
      end else begin
         cnt       <= tick_h ? '0 : cnt + CW'(1);
         state     <= state_nxt;
         if (tick_h) ctl_prev <= clk_ctl_h;
         dblerr    <= dblerr | dbl_set;
         cs_err_ff <= (tick_h & cs_par_err_h) | (cs_err_ff & ~(adv & ird1));
         mt_prev   <= micro_trap_l;
         stall_ff  <= (fall | stall_ff) & ~tick_h;
         utrap_ff  <= fall | (utrap_ff & ~adv);
         if (adv) svc_reg <= (ird1 & gen_dest_inh_l) ? pend : utrap_ff ? svc_reg : '0;
         if (adv) ird_ctr_h <= ird_nxt;
      end
   end
endmodule

// File: tb/tb_sac_seq_ctl.sv
// tb_sac_seq_ctl: directed checks of sac_seq_ctl with DIV=3, NTRAP=6, IRD_W=3
module tb_sac_seq_ctl;
   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] clk_ctl_h;
   logic       mem_stall_h, gen_dest_inh_l, cs_par_err_h, micro_trap_l, but_cc_a_h;
   logic [2:0] but_h;
   logic [5:0] trap_req_h, trap_mask_h;
   logic       tick_h, mken_h, dken_h, halt_l, do_service_l, uvector_h;
   logic [3:0] trap_vec_h;
   logic [2:0] ird_ctr_h;
   int         checks = 0;
   int         failures = 0;
   sac_seq_ctl #(.DIV(3), .NTRAP(6), .VEC_W(4), .IRD_W(3)) dut (
      .base_clk_h(clk), .sac_reset_h(rst), .clk_ctl_h(clk_ctl_h), .mem_stall_h(mem_stall_h),
      .gen_dest_inh_l(gen_dest_inh_l), .cs_par_err_h(cs_par_err_h), .micro_trap_l(micro_trap_l),
      .but_cc_a_h(but_cc_a_h), .but_h(but_h), .trap_req_h(trap_req_h), .trap_mask_h(trap_mask_h),
      .tick_h(tick_h), .mken_h(mken_h), .dken_h(dken_h), .halt_l(halt_l),
      .do_service_l(do_service_l), .trap_vec_h(trap_vec_h), .uvector_h(uvector_h),
      .ird_ctr_h(ird_ctr_h)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic cyc;
      @(posedge clk);
      #2;
   endtask
   task automatic next_tick;
      int n;
      n = 0;
      cyc();
      while (!tick_h && n < 8) begin
         cyc();
         n++;
      end
      chk("tick_seen", 32'(tick_h), 1);
   endtask
   initial begin
      rst = 1'b1; clk_ctl_h = 2'd3; mem_stall_h = 1'b0; gen_dest_inh_l = 1'b1;
      cs_par_err_h = 1'b0; micro_trap_l = 1'b1; but_cc_a_h = 1'b0; but_h = 3'd0;
      trap_req_h = 6'd0; trap_mask_h = 6'b111111;
      repeat (3) cyc();
      chk("rst_tick", 32'(tick_h), 0);
      chk("rst_mken", 32'(mken_h), 0);
      chk("rst_dken", 32'(dken_h), 0);
      chk("rst_halt_l", 32'(halt_l), 0);
      chk("rst_uvec", 32'(uvector_h), 0);
      chk("rst_dsl", 32'(do_service_l), 1);
      chk("rst_ird", 32'(ird_ctr_h), 0);
      chk("rst_vec", 32'(trap_vec_h), 0);
      rst = 1'b0;
      // first tick two cycles after release, then RUN
      cyc();
      chk("c1_tick", 32'(tick_h), 0);
      cyc();
      chk("c2_tick", 32'(tick_h), 1);
      chk("c2_mken", 32'(mken_h), 0);
      chk("c2_halt_l", 32'(halt_l), 0);
      cyc();
      chk("c3_halt_l", 32'(halt_l), 1);
      chk("c3_mken", 32'(mken_h), 0);
      cyc();
      cyc();
      chk("c5_tick", 32'(tick_h), 1);
      chk("c5_mken", 32'(mken_h), 1);
      chk("c5_dken", 32'(dken_h), 1);
      gen_dest_inh_l = 1'b0;
      #1;
      chk("inh_dken", 32'(dken_h), 0);
      chk("inh_mken", 32'(mken_h), 1);
      // IRD1 with traps pending, then IRD counter sequence
      gen_dest_inh_l = 1'b1; but_cc_a_h = 1'b1; but_h = 3'd4; trap_req_h = 6'b010100;
      cyc();
      chk("ird1_ctr", 32'(ird_ctr_h), 7);
      chk("trap_vec", 32'(trap_vec_h), 2);
      chk("trap_dsl", 32'(do_service_l), 0);
      cs_par_err_h = 1'b1;
      #1;
      chk("par_gate_dsl", 32'(do_service_l), 1);
      cs_par_err_h = 1'b0;
      next_tick();
      but_cc_a_h = 1'b0; but_h = 3'd6;
      cyc();
      chk("ird_wrap", 32'(ird_ctr_h), 0);
      chk("svc_clr_dsl", 32'(do_service_l), 1);
      chk("svc_clr_vec", 32'(trap_vec_h), 0);
      next_tick();
      but_h = 3'd1;
      cyc();
      chk("ird_inc1", 32'(ird_ctr_h), 1);
      next_tick();
      cyc();
      chk("ird_inc2", 32'(ird_ctr_h), 2);
      next_tick();
      cyc();
      chk("ird_hold", 32'(ird_ctr_h), 2);
      // reset on a tick discards the pending update
      next_tick();
      but_h = 3'd6; rst = 1'b1;
      cyc();
      chk("mid_rst_ird", 32'(ird_ctr_h), 0);
      chk("mid_rst_halt_l", 32'(halt_l), 0);
      chk("mid_rst_tick", 32'(tick_h), 0);
      chk("mid_rst_dsl", 32'(do_service_l), 1);
      rst = 1'b0; but_h = 3'd0;
      cyc();
      cyc();
      chk("mid_rst_tick2", 32'(tick_h), 1);
      cyc();
      chk("mid_rst_run", 32'(halt_l), 1);
      // masked trap and stall holding counter and service
      next_tick();
      trap_mask_h = 6'b111011; but_cc_a_h = 1'b1; but_h = 3'd5; trap_req_h = 6'b010100;
      cyc();
      chk("mask_vec", 32'(trap_vec_h), 4);
      chk("mask_dsl", 32'(do_service_l), 0);
      chk("mask_ird", 32'(ird_ctr_h), 7);
      next_tick();
      but_cc_a_h = 1'b0; but_h = 3'd6; mem_stall_h = 1'b1;
      #1;
      chk("stall_mken", 32'(mken_h), 0);
      cyc();
      chk("stall_ird", 32'(ird_ctr_h), 7);
      chk("stall_dsl", 32'(do_service_l), 0);
      mem_stall_h = 1'b0;
      next_tick();
      chk("unstall_mken", 32'(mken_h), 1);
      cyc();
      chk("unstall_ird", 32'(ird_ctr_h), 0);
      chk("unstall_dsl", 32'(do_service_l), 1);
      but_h = 3'd0; trap_mask_h = 6'b111111; trap_req_h = 6'd0;
      // halt, single step, stalled single step
      next_tick();
      clk_ctl_h = 2'd0;
      cyc();
      chk("stop_halt_l", 32'(halt_l), 0);
      next_tick();
      chk("halted_mken", 32'(mken_h), 0);
      clk_ctl_h = 2'd2;
      cyc();
      chk("step_halt_l", 32'(halt_l), 1);
      next_tick();
      chk("step_mken", 32'(mken_h), 1);
      cyc();
      chk("step_done", 32'(halt_l), 0);
      next_tick();
      chk("step_once", 32'(mken_h), 0);
      clk_ctl_h = 2'd1;
      cyc();
      next_tick();
      clk_ctl_h = 2'd2;
      cyc();
      chk("step2_halt_l", 32'(halt_l), 1);
      next_tick();
      mem_stall_h = 1'b1;
      #1;
      chk("step2_stall_mken", 32'(mken_h), 0);
      cyc();
      chk("step2_stall_halt_l", 32'(halt_l), 1);
      mem_stall_h = 1'b0;
      next_tick();
      chk("step2_mken", 32'(mken_h), 1);
      cyc();
      chk("step2_done", 32'(halt_l), 0);
      next_tick();
      clk_ctl_h = 2'd3;
      cyc();
      chk("rerun_halt_l", 32'(halt_l), 1);
      // microtrap coinciding with IRD1 trap
      micro_trap_l = 1'b0; but_cc_a_h = 1'b1; but_h = 3'd4; trap_req_h = 6'b001000;
      cyc();
      cyc();
      chk("ut_tick", 32'(tick_h), 1);
      chk("ut_supp_mken", 32'(mken_h), 0);
      chk("ut_uvec0", 32'(uvector_h), 0);
      cyc();
      chk("ut_uvec1", 32'(uvector_h), 1);
      chk("ut_dsl", 32'(do_service_l), 1);
      chk("ut_ird_held", 32'(ird_ctr_h), 0);
      next_tick();
      chk("ut_adv", 32'(mken_h), 1);
      cyc();
      chk("ut_clear_uvec", 32'(uvector_h), 0);
      chk("ut_svc_dsl", 32'(do_service_l), 0);
      chk("ut_svc_vec", 32'(trap_vec_h), 3);
      chk("ut_ird", 32'(ird_ctr_h), 7);
      but_cc_a_h = 1'b0; but_h = 3'd0;
      next_tick();
      chk("ut_no_retrig", 32'(mken_h), 1);
      cyc();
      chk("ut_svc_end", 32'(do_service_l), 1);
      micro_trap_l = 1'b1;
      // microtrap arriving while service latched
      next_tick();
      but_cc_a_h = 1'b1; but_h = 3'd4;
      cyc();
      chk("ut2_svc", 32'(do_service_l), 0);
      but_cc_a_h = 1'b0; but_h = 3'd0; micro_trap_l = 1'b0;
      cyc();
      chk("ut2_dsl_hide", 32'(do_service_l), 1);
      chk("ut2_uvec0", 32'(uvector_h), 0);
      next_tick();
      chk("ut2_supp", 32'(mken_h), 0);
      cyc();
      chk("ut2_uvec1", 32'(uvector_h), 1);
      chk("ut2_dsl", 32'(do_service_l), 1);
      next_tick();
      chk("ut2_adv", 32'(mken_h), 1);
      cyc();
      chk("ut2_uvec_clr", 32'(uvector_h), 0);
      chk("ut2_svc_held", 32'(do_service_l), 0);
      chk("ut2_vec", 32'(trap_vec_h), 3);
      micro_trap_l = 1'b1;
      next_tick();
      cyc();
      chk("ut2_svc_end", 32'(do_service_l), 1);
      trap_req_h = 6'd0;
      // parity errors: single cleared by IRD1, then double halts sticky
      next_tick();
      cs_par_err_h = 1'b1;
      cyc();
      cs_par_err_h = 1'b0;
      chk("par1_halt_l", 32'(halt_l), 1);
      next_tick();
      but_cc_a_h = 1'b1; but_h = 3'd4;
      cyc();
      but_cc_a_h = 1'b0; but_h = 3'd0;
      next_tick();
      cs_par_err_h = 1'b1;
      cyc();
      cs_par_err_h = 1'b0;
      chk("par_cleared", 32'(halt_l), 1);
      next_tick();
      cs_par_err_h = 1'b1;
      cyc();
      cs_par_err_h = 1'b0;
      chk("dblerr_halt", 32'(halt_l), 0);
      next_tick();
      chk("dblerr_mken", 32'(mken_h), 0);
      clk_ctl_h = 2'd0;
      cyc();
      chk("dblerr_run", 32'(halt_l), 0);
      next_tick();
      clk_ctl_h = 2'd2;
      cyc();
      chk("dblerr_step", 32'(halt_l), 0);
      clk_ctl_h = 2'd3;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      cyc();
      cyc();
      cyc();
      chk("dblerr_rst_run", 32'(halt_l), 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
